// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory among four requesters:
//   0 = register-file X/Y port, 1 = accumulator port,
//   2 = PC stack port,          3 = crypto core data port.
// One access is granted per cycle using round-robin priority. A requester that
// holds lock keeps ownership for a burst of back-to-back accesses. A lock held
// for LOCK_MAX cycles is released by force. Read data returns one cycle after
// the access with a one-hot valid tag.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req/we/lock     per-requester request, write enable and burst lock
//   addr/wdata      packed per-requester address and write data
//                   (requester i at [i*W +: W])
//   gnt             one-hot grant, combinational
//   rvalid          one-hot read-data valid, registered
//   rdata           read data, forced to zero unless some rvalid bit is set
//   mem_*           memory-side access fields, all zero when nothing is granted
//   mem_rdata       memory read data, one cycle after the access edge
//   lock_timeout    one-cycle pulse after a forced lock release
//   locked          high while the arbiter is in the LOCKED state
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [3:0]            lock,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  lock_timeout,
  output logic                  locked
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam int              CNT_W   = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic [0:0]       state;
  logic [1:0]       owner;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] lock_cnt;

  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;

  // Grant selection. While locked only the owner can be granted; otherwise
  // the first asserted request searching upward from ptr wins.
  // NOTE: every variable written in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (state == ST_LOCKED) begin
      gnt_any = req[owner];
      gnt_idx = owner;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cand = ptr + 2'(i);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

  // Memory-side mux; everything stays zero on idle cycles.
  always_comb begin
    mem_en    = gnt_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_we    = we[gnt_idx];
      mem_addr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_wdata = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_UNLOCKED;
      owner        <= 2'd0;
      ptr          <= 2'd0;
      lock_cnt     <= '0;
      rvalid       <= 4'b0000;
      lock_timeout <= 1'b0;
    end else begin
      // Only reads return data; gnt is one-hot, so mem_we is the granted we.
      rvalid       <= gnt & {4{~mem_we}};
      lock_timeout <= 1'b0;
      if (state == ST_UNLOCKED) begin
        if (gnt_any) begin
          ptr <= gnt_idx + 2'd1;
          if (lock[gnt_idx]) begin
            state    <= ST_LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= '0;
          end
        end
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
        // Timeout wins over the other release causes so that a simultaneous
        // drop of req still yields a single release with a timeout pulse.
        if (lock_cnt == CNT_LAST) begin
          state        <= ST_UNLOCKED;
          lock_timeout <= 1'b1;
          ptr          <= owner + 2'd1;
        end else if (!req[owner] || !lock[owner]) begin
          state <= ST_UNLOCKED;
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign rdata  = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter. A small behavioural memory answers
// reads one cycle after the access edge; its initial contents are 16'hC000|addr
// so expected read data follows directly from the address. Inputs are driven
// 1 time unit after the rising edge and outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int LOCK_MAX = 16;

  logic                   clk;
  logic                   rst;
  logic [3:0]             req;
  logic [3:0]             we;
  logic [3:0]             lock;
  logic [3:0][ADDR_W-1:0] addr_v;
  logic [3:0][DATA_W-1:0] wdata_v;
  logic [3:0]             gnt;
  logic [3:0]             rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   lock_timeout;
  logic                   locked;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [512];

  dmem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .lock        (lock),
    .addr        (addr_v),
    .wdata       (wdata_v),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .lock_timeout(lock_timeout),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle read latency.
  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 16'hC000 | 16'(a);
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    we      = 4'b0000;
    lock    = 4'b0000;
    addr_v  = {9'h1F4, 9'h133, 9'h022, 9'h011};
    wdata_v = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};

    // Reset state
    #3;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_locked", locked, 1'b0);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_timeout", lock_timeout, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    tick();
    rst = 1'b0;

    // Round-robin: all four reading, grants 0,1,2,3,0 with rvalid one cycle later
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", gnt, 32'(1) << (i % 4));
      chk("rr_addr", mem_addr, addr_v[i % 4]);
      tick();
      chk("rr_rvalid", rvalid, 32'(1) << (i % 4));
      chk("rr_rdata", rdata, 16'hC000 | 16'(addr_v[i % 4]));
    end
    req = 4'b0000;
    #1;
    chk("rr_idle_gnt", gnt, 4'b0000);
    // ptr is now 1

    // Write path on requester 1
    addr_v[1]  = 9'h05A;
    wdata_v[1] = 16'hBEEF;
    req = 4'b0010;
    we  = 4'b0010;
    #1;
    chk("wr_gnt", gnt, 4'b0010);
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 9'h05A);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    req = 4'b0000;
    we  = 4'b0000;
    addr_v[1] = 9'h022;
    #1;
    chk("wr_rvalid", rvalid, 4'b0000);
    tick();
    chk("wr_rvalid2", rvalid, 4'b0000);
    // ptr is now 2

    // Locked burst: one grant to 2 moves ptr to 3, then crypto bursts 4 reads
    req = 4'b0100;
    #1;
    tick();
    req  = 4'b1001;
    lock = 4'b1000;
    #1;
    chk("burst_c1_gnt", gnt, 4'b1000);
    chk("burst_c1_locked", locked, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) lock = 4'b0000;
      #1;
      chk("burst_locked", locked, 1'b1);
      chk("burst_gnt", gnt, 4'b1000);
      chk("burst_rvalid", rvalid, 4'b1000);
      chk("burst_rdata", rdata, 16'hC1F4);
    end
    tick();
    chk("burst_c5_locked", locked, 1'b0);
    chk("burst_c5_gnt", gnt, 4'b0001);
    chk("burst_c5_rvalid", rvalid, 4'b1000);
    tick();
    req = 4'b0000;
    #1;
    chk("burst_last_rvalid", rvalid, 4'b0001);
    // ptr is now 1

    // Timeout: ptr to 3 via requester 2, then crypto holds lock with req[2] up
    req = 4'b0100;
    #1;
    tick();
    req  = 4'b1100;
    lock = 4'b1000;
    #1;
    chk("to_lock_gnt", gnt, 4'b1000);
    tick();
    for (int c = 0; c < LOCK_MAX; c++) begin
      chk("to_gnt", gnt, 4'b1000);
      chk("to_locked", locked, 1'b1);
      chk("to_pulse_low", lock_timeout, 1'b0);
      tick();
    end
    chk("to_released", locked, 1'b0);
    chk("to_pulse", lock_timeout, 1'b1);
    chk("to_next_gnt", gnt, 4'b0100);
    lock = 4'b0000;
    tick();
    chk("to_pulse_once", lock_timeout, 1'b0);
    chk("to_ptr3_gnt", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    #1;
    // ptr is now 0

    // Async reset while locked with a pending rvalid[3]
    req  = 4'b1000;
    lock = 4'b1000;
    #1;
    chk("ar_gnt", gnt, 4'b1000);
    tick();
    tick();
    chk("ar_locked", locked, 1'b1);
    chk("ar_rvalid", rvalid, 4'b1000);
    rst = 1'b1;
    req = 4'b1111;
    #1;
    chk("ar_locked_clr", locked, 1'b0);
    chk("ar_rvalid_clr", rvalid, 4'b0000);
    chk("ar_gnt_ptr0", gnt, 4'b0001);
    tick();
    rst  = 1'b0;
    req  = 4'b0100;
    lock = 4'b0000;
    #1;
    chk("ar_after_gnt", gnt, 4'b0100);
    tick();
    // ptr is now 3

    // Owner drops req in the very cycle the timeout fires
    req  = 4'b1000;
    lock = 4'b1000;
    #1;
    chk("sim_gnt", gnt, 4'b1000);
    tick();
    for (int c = 0; c < LOCK_MAX - 1; c++) tick();
    req = 4'b0000;
    #1;
    chk("sim_no_gnt", gnt, 4'b0000);
    chk("sim_still_locked", locked, 1'b1);
    tick();
    chk("sim_released", locked, 1'b0);
    chk("sim_pulse", lock_timeout, 1'b1);
    tick();
    chk("sim_pulse_once", lock_timeout, 1'b0);
    chk("sim_locked_low", locked, 1'b0);
    lock = 4'b0000;

    // Idle: nothing requested for 10 cycles, memory side stays quiet
    we = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_mem_en", mem_en, 1'b0);
      chk("idle_mem_we", mem_we, 1'b0);
      chk("idle_mem_addr", mem_addr, '0);
      chk("idle_mem_wdata", mem_wdata, '0);
      chk("idle_rvalid", rvalid, 4'b0000);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
